// File: rtl/posture_alarm_ctrl.sv
// Frame-level controller behind the per-pixel Y/angle threshold checker: owns the
// checker thresholds (swapped at frame start), counts flagged pixels, debounces alarm.
module posture_alarm_ctrl #(
  parameter int unsigned TH_WID     = 8,
  parameter int unsigned CNT_WID    = 20,
  parameter int unsigned BAD_FRAMES = 3,
  parameter int unsigned CLR_FRAMES = 5,
  parameter int unsigned Y_MIN_DEF  = 20,
  parameter int unsigned Y_MAX_DEF  = 200,
  parameter int unsigned ANG_DEF    = 60,
  parameter int unsigned PIX_TH_DEF = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [TH_WID-1:0]  cfg_y_min,
  input  logic [TH_WID-1:0]  cfg_y_max,
  input  logic [TH_WID-1:0]  cfg_angle_th,
  input  logic [CNT_WID-1:0] cfg_pix_th,
  input  logic               vs_in,
  input  logic               de_in,
  input  logic               y_th_flag,
  input  logic               angle_th_flag,
  output logic [TH_WID-1:0]  y_min,
  output logic [TH_WID-1:0]  y_max,
  output logic [TH_WID-1:0]  angle_th,
  output logic [CNT_WID-1:0] frame_y_cnt,
  output logic [CNT_WID-1:0] frame_ang_cnt,
  output logic               frame_valid,
  output logic               alarm,
  output logic               alarm_pulse,
  output logic [2:0]         state_o
);

  localparam int unsigned BW = $clog2(BAD_FRAMES + 1);
  localparam int unsigned GW = $clog2(CLR_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MONITOR = 3'd1,
    SUSPECT = 3'd2,
    ALARM   = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               vs_q;
  logic               fs, y_hit, a_hit, bad;
  logic [TH_WID-1:0]  sh_y_min_q, sh_y_min_d, sh_y_max_q, sh_y_max_d, sh_ang_q, sh_ang_d;
  logic [CNT_WID-1:0] sh_pix_th_q, sh_pix_th_d, pix_th_q, pix_th_d;
  logic [TH_WID-1:0]  y_min_q, y_min_d, y_max_q, y_max_d, ang_q, ang_d;
  logic [CNT_WID-1:0] y_cnt_q, y_cnt_d, ang_cnt_q, ang_cnt_d;
  logic [CNT_WID-1:0] frame_y_cnt_q, frame_y_cnt_d, frame_ang_cnt_q, frame_ang_cnt_d;
  logic               frame_valid_q, frame_valid_d, alarm_q, alarm_d;
  logic               alarm_pulse_q, alarm_pulse_d;
  logic [BW-1:0]      bad_cnt_q, bad_cnt_d, bad_inc;
  logic [GW-1:0]      good_cnt_q, good_cnt_d, good_inc;

  assign fs       = vs_in & ~vs_q;
  assign y_hit    = de_in & y_th_flag;
  assign a_hit    = de_in & angle_th_flag;
  assign bad      = (y_cnt_q >= pix_th_q) | (ang_cnt_q >= pix_th_q);
  assign bad_inc  = bad_cnt_q + BW'(1);
  assign good_inc = good_cnt_q + GW'(1);

  always_comb begin
    state_d         = state_q;
    sh_y_min_d      = sh_y_min_q;
    sh_y_max_d      = sh_y_max_q;
    sh_ang_d        = sh_ang_q;
    sh_pix_th_d     = sh_pix_th_q;
    y_min_d         = y_min_q;
    y_max_d         = y_max_q;
    ang_d           = ang_q;
    pix_th_d        = pix_th_q;
    y_cnt_d         = y_cnt_q;
    ang_cnt_d       = ang_cnt_q;
    frame_y_cnt_d   = frame_y_cnt_q;
    frame_ang_cnt_d = frame_ang_cnt_q;
    frame_valid_d   = 1'b0;
    alarm_pulse_d   = 1'b0;
    bad_cnt_d       = bad_cnt_q;
    good_cnt_d      = good_cnt_q;

    if (cfg_we) begin
      sh_y_min_d  = cfg_y_min;
      sh_y_max_d  = cfg_y_max;
      sh_ang_d    = cfg_angle_th;
      sh_pix_th_d = cfg_pix_th;
    end

    if (y_hit && (y_cnt_q != '1))   y_cnt_d   = y_cnt_q + CNT_WID'(1);
    if (a_hit && (ang_cnt_q != '1)) ang_cnt_d = ang_cnt_q + CNT_WID'(1);

    if (fs) begin
      // the pixel presented on the fs cycle already belongs to the new frame
      y_cnt_d   = CNT_WID'(y_hit);
      ang_cnt_d = CNT_WID'(a_hit);
      y_min_d   = cfg_we ? cfg_y_min    : sh_y_min_q;
      y_max_d   = cfg_we ? cfg_y_max    : sh_y_max_q;
      ang_d     = cfg_we ? cfg_angle_th : sh_ang_q;
      pix_th_d  = cfg_we ? cfg_pix_th   : sh_pix_th_q;
      if (state_q != IDLE) begin
        frame_y_cnt_d   = y_cnt_q;
        frame_ang_cnt_d = ang_cnt_q;
        frame_valid_d   = 1'b1;
      end
      unique case (state_q)
        IDLE: state_d = MONITOR;
        MONITOR: if (bad) begin
          if (BAD_FRAMES == 1) begin
            state_d       = ALARM;
            bad_cnt_d     = '0;
            alarm_pulse_d = 1'b1;
          end else begin
            state_d   = SUSPECT;
            bad_cnt_d = BW'(1);
          end
        end
        SUSPECT: if (bad) begin
          if (bad_inc >= BW'(BAD_FRAMES)) begin
            state_d       = ALARM;
            bad_cnt_d     = '0;
            alarm_pulse_d = 1'b1;
          end else begin
            bad_cnt_d = bad_inc;
          end
        end else begin
          state_d   = MONITOR;
          bad_cnt_d = '0;
        end
        ALARM: if (!bad) begin
          if (CLR_FRAMES == 1) begin
            state_d    = MONITOR;
            good_cnt_d = '0;
          end else begin
            state_d    = RECOVER;
            good_cnt_d = GW'(1);
          end
        end
        RECOVER: if (bad) begin
          state_d    = ALARM;
          good_cnt_d = '0;
        end else if (good_inc >= GW'(CLR_FRAMES)) begin
          state_d    = MONITOR;
          good_cnt_d = '0;
        end else begin
          good_cnt_d = good_inc;
        end
        default: state_d = IDLE;
      endcase
    end

    alarm_d = (state_d == ALARM) || (state_d == RECOVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      vs_q            <= 1'b0;
      sh_y_min_q      <= TH_WID'(Y_MIN_DEF);
      sh_y_max_q      <= TH_WID'(Y_MAX_DEF);
      sh_ang_q        <= TH_WID'(ANG_DEF);
      sh_pix_th_q     <= CNT_WID'(PIX_TH_DEF);
      y_min_q         <= TH_WID'(Y_MIN_DEF);
      y_max_q         <= TH_WID'(Y_MAX_DEF);
      ang_q           <= TH_WID'(ANG_DEF);
      pix_th_q        <= CNT_WID'(PIX_TH_DEF);
      y_cnt_q         <= '0;
      ang_cnt_q       <= '0;
      frame_y_cnt_q   <= '0;
      frame_ang_cnt_q <= '0;
      frame_valid_q   <= 1'b0;
      alarm_q         <= 1'b0;
      alarm_pulse_q   <= 1'b0;
      bad_cnt_q       <= '0;
      good_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      vs_q            <= vs_in;
      sh_y_min_q      <= sh_y_min_d;
      sh_y_max_q      <= sh_y_max_d;
      sh_ang_q        <= sh_ang_d;
      sh_pix_th_q     <= sh_pix_th_d;
      y_min_q         <= y_min_d;
      y_max_q         <= y_max_d;
      ang_q           <= ang_d;
      pix_th_q        <= pix_th_d;
      y_cnt_q         <= y_cnt_d;
      ang_cnt_q       <= ang_cnt_d;
      frame_y_cnt_q   <= frame_y_cnt_d;
      frame_ang_cnt_q <= frame_ang_cnt_d;
      frame_valid_q   <= frame_valid_d;
      alarm_q         <= alarm_d;
      alarm_pulse_q   <= alarm_pulse_d;
      bad_cnt_q       <= bad_cnt_d;
      good_cnt_q      <= good_cnt_d;
    end
  end

  assign y_min         = y_min_q;
  assign y_max         = y_max_q;
  assign angle_th      = ang_q;
  assign frame_y_cnt   = frame_y_cnt_q;
  assign frame_ang_cnt = frame_ang_cnt_q;
  assign frame_valid   = frame_valid_q;
  assign alarm         = alarm_q;
  assign alarm_pulse   = alarm_pulse_q;
  assign state_o       = state_q;

endmodule
